// File: rtl/exception_result_unit_pkg.sv
// Shared definitions for the 8-bit FPU exception path: format fields, op codes,
// canonical special encodings and FSM states.
// Pure declarations, no logic or latency of its own.
package exception_result_unit_pkg;

    // sign[7], exponent[6:3] (bias 7), mantissa[2:0]
    localparam int unsigned FP_W     = 8;
    localparam int unsigned SIGN_BIT = 7;
    localparam int unsigned EXP_MSB  = 6;
    localparam int unsigned EXP_LSB  = 3;
    localparam int unsigned MAN_MSB  = 2;
    localparam int unsigned MAN_LSB  = 0;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    localparam logic [FP_W-1:0] FP_NAN   = 8'h7C;
    localparam logic [FP_W-1:0] FP_PINF  = 8'h78;
    localparam logic [FP_W-1:0] FP_NINF  = 8'hF8;
    localparam logic [FP_W-1:0] FP_PZERO = 8'h00;
    localparam logic [FP_W-1:0] FP_NZERO = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic invalid;
        logic div0;
        logic inf;
    } exc_flags_t;

    function automatic logic [FP_W-1:0] signed_inf(input logic s);
        return s ? FP_NINF : FP_PINF;
    endfunction

    function automatic logic [FP_W-1:0] signed_zero(input logic s);
        return s ? FP_NZERO : FP_PZERO;
    endfunction

endpackage

// File: rtl/exception_result_unit_fp8_classifier.sv
// Classifies one 8-bit float operand as NaN / Inf / Zero and extracts its sign.
// Purely combinational, zero latency.
// No handshake; subnormals are reported as ordinary finite values.
module fp8_classifier
    import exception_result_unit_pkg::*;
(
    input  logic [FP_W-1:0] fp_i,
    output logic            is_nan_o,
    output logic            is_inf_o,
    output logic            is_zero_o,
    output logic            sign_o
);

    logic [EXP_MSB-EXP_LSB:0] exp_f;
    logic [MAN_MSB-MAN_LSB:0] man_f;
    logic                     exp_max;

    assign exp_f   = fp_i[EXP_MSB:EXP_LSB];
    assign man_f   = fp_i[MAN_MSB:MAN_LSB];
    assign exp_max = &exp_f;

    assign is_nan_o  = exp_max && (man_f != '0);
    assign is_inf_o  = exp_max && (man_f == '0);
    assign is_zero_o = (exp_f == '0) && (man_f == '0);
    assign sign_o    = fp_i[SIGN_BIT];

endmodule

// File: rtl/exception_result_unit.sv
// Special-case (NaN/Inf/Zero) result generator with sticky flags and saturating counter.
// Latency: accept -> EVAL -> HOLD (out_valid) ; one result per 3 cycles at best.
// Backpressure: result is held stable in HOLD until out_ready; in_ready low outside IDLE.
module exception_result_unit
    import exception_result_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [FP_W-1:0] in0,
    input  logic [FP_W-1:0] in1,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] res_data,
    output logic            res_special,
    input  logic            flags_clr,
    output logic            flag_invalid,
    output logic            flag_div0,
    output logic            flag_inf,
    output logic [7:0]      exc_count
);

    state_e          state_q, state_d;
    logic            load;
    op_e             op_q;
    logic [FP_W-1:0] a_q, b_q;
    logic [FP_W-1:0] res_q, rule_res;
    logic            spec_q, rule_spec;
    exc_flags_t      flags_q, flags_d, rule_set;
    logic [7:0]      cnt_q, cnt_d;
    logic            eval;

    logic a_nan, a_inf, a_zero, a_sign;
    logic b_nan, b_inf, b_zero, b_sign;
    logic b_sign_eff, prod_sign;

    fp8_classifier u_cls_a (
        .fp_i      (a_q),
        .is_nan_o  (a_nan),
        .is_inf_o  (a_inf),
        .is_zero_o (a_zero),
        .sign_o    (a_sign)
    );

    fp8_classifier u_cls_b (
        .fp_i      (b_q),
        .is_nan_o  (b_nan),
        .is_inf_o  (b_inf),
        .is_zero_o (b_zero),
        .sign_o    (b_sign)
    );

    assign eval      = (state_q == ST_EVAL);
    // Ready is forced low while reset is held, even though the state register sits in IDLE.
    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_HOLD);

    // Next-state logic: IDLE -> EVAL on accept, EVAL -> HOLD, HOLD -> IDLE on out_ready.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: state_d = ST_HOLD;
            ST_HOLD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Capture the request; inputs are ignored outside IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= OP_ADD;
            a_q  <= '0;
            b_q  <= '0;
        end else if (load) begin
            op_q <= op_e'(in_op);
            a_q  <= in0;
            b_q  <= in1;
        end
    end

    // Special-case rules in priority order; SUB is ADD with the second sign flipped.
    always_comb begin
        rule_res   = FP_PZERO;
        rule_spec  = 1'b0;
        rule_set   = '0;
        b_sign_eff = b_sign ^ (op_q == OP_SUB);
        prod_sign  = a_sign ^ b_sign;
        if (a_nan || b_nan) begin
            rule_res         = FP_NAN;
            rule_spec        = 1'b1;
            rule_set.invalid = 1'b1;
        end else begin
            case (op_q)
                OP_ADD, OP_SUB: begin
                    if (a_inf && b_inf && (a_sign != b_sign_eff)) begin
                        rule_res         = FP_NAN;
                        rule_spec        = 1'b1;
                        rule_set.invalid = 1'b1;
                    end else if (a_inf || b_inf) begin
                        rule_res     = signed_inf(a_inf ? a_sign : b_sign_eff);
                        rule_spec    = 1'b1;
                        rule_set.inf = 1'b1;
                    end
                end
                OP_MUL: begin
                    if ((a_inf && b_zero) || (a_zero && b_inf)) begin
                        rule_res         = FP_NAN;
                        rule_spec        = 1'b1;
                        rule_set.invalid = 1'b1;
                    end else if (a_inf || b_inf) begin
                        rule_res     = signed_inf(prod_sign);
                        rule_spec    = 1'b1;
                        rule_set.inf = 1'b1;
                    end
                end
                OP_DIV: begin
                    if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                        rule_res         = FP_NAN;
                        rule_spec        = 1'b1;
                        rule_set.invalid = 1'b1;
                    end else if (a_inf) begin
                        rule_res     = signed_inf(prod_sign);
                        rule_spec    = 1'b1;
                        rule_set.inf = 1'b1;
                    end else if (b_inf) begin
                        rule_res  = signed_zero(prod_sign);
                        rule_spec = 1'b1;
                    end else if (b_zero) begin
                        rule_res      = signed_inf(prod_sign);
                        rule_spec     = 1'b1;
                        rule_set.div0 = 1'b1;
                        rule_set.inf  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result register: written only in EVAL so HOLD presents a stable value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            spec_q <= 1'b0;
        end else if (eval) begin
            res_q  <= rule_res;
            spec_q <= rule_spec;
        end
    end

    // Sticky flags and counter next state: a set in EVAL overrides a same-cycle clear.
    always_comb begin
        flags_d = flags_clr ? exc_flags_t'('0) : flags_q;
        cnt_d   = flags_clr ? 8'h00 : cnt_q;
        if (eval) begin
            flags_d = flags_d | rule_set;
            if (rule_spec && (cnt_d != 8'hFF)) cnt_d = cnt_d + 8'h01;
        end
    end

    // Sticky flag and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    assign res_data     = res_q;
    assign res_special  = spec_q;
    assign flag_invalid = flags_q.invalid;
    assign flag_div0    = flags_q.div0;
    assign flag_inf     = flags_q.inf;
    assign exc_count    = cnt_q;

endmodule

// File: tb/tb_exception_result_unit.sv
// Bench for exception_result_unit: table vectors, hand sequences and randomized
// requests checked against a class-based reference model of the special-case rules.
// Clock 10 time units; inputs driven and outputs sampled on the falling edge.
module tb_exception_result_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [7:0] in0, in1;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] res_data;
    logic       res_special;
    logic       flags_clr;
    logic       flag_invalid, flag_div0, flag_inf;
    logic [7:0] exc_count;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit m_inv, m_dz, m_inf;
    int m_cnt;

    always #5 clk = ~clk;

    exception_result_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in0          (in0),
        .in1          (in1),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .res_data     (res_data),
        .res_special  (res_special),
        .flags_clr    (flags_clr),
        .flag_invalid (flag_invalid),
        .flag_div0    (flag_div0),
        .flag_inf     (flag_inf),
        .exc_count    (exc_count)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h required %02h", name, act, exp);
        end
    endtask

    // operand kind: 0 finite nonzero, 1 zero, 2 infinity, 3 NaN
    function automatic int kind(input logic [7:0] x);
        int e = int'(x[6:3]);
        int m = int'(x[2:0]);
        if (e == 15) return (m != 0) ? 3 : 2;
        if (e == 0 && m == 0) return 1;
        return 0;
    endfunction

    function automatic void ref_eval(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                     output logic [7:0] d, output bit sp, output bit inv,
                                     output bit dz, output bit inf);
        int  ka = kind(a);
        int  kb = kind(b);
        bit  sa = a[7];
        bit  sb = (op == 2'd1) ? !b[7] : b[7];
        bit  sx = a[7] ^ b[7];
        d = 8'h00; sp = 0; inv = 0; dz = 0; inf = 0;
        if (ka == 3 || kb == 3) begin
            d = 8'h7C; sp = 1; inv = 1;
        end else if (op == 2'd0 || op == 2'd1) begin
            if (ka == 2 && kb == 2 && sa != sb) begin d = 8'h7C; sp = 1; inv = 1; end
            else if (ka == 2 || kb == 2) begin
                d = ((ka == 2) ? sa : sb) ? 8'hF8 : 8'h78; sp = 1; inf = 1;
            end
        end else if (op == 2'd2) begin
            if ((ka == 2 && kb == 1) || (ka == 1 && kb == 2)) begin d = 8'h7C; sp = 1; inv = 1; end
            else if (ka == 2 || kb == 2) begin d = sx ? 8'hF8 : 8'h78; sp = 1; inf = 1; end
        end else begin
            if (ka == kb && (ka == 1 || ka == 2)) begin d = 8'h7C; sp = 1; inv = 1; end
            else if (ka == 2) begin d = sx ? 8'hF8 : 8'h78; sp = 1; inf = 1; end
            else if (kb == 2) begin d = sx ? 8'h80 : 8'h00; sp = 1; end
            else if (kb == 1) begin d = sx ? 8'hF8 : 8'h78; sp = 1; dz = 1; inf = 1; end
        end
    endfunction

    task automatic chk_status(input string name);
        chk({name, ".flags"}, {5'b0, flag_invalid, flag_div0, flag_inf}, {5'b0, m_inv, m_dz, m_inf});
        chk({name, ".count"}, exc_count, 8'(m_cnt));
    endtask

    // One full request/response. use_exp selects the table's expectation over the model's.
    task automatic txn(input string name, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit clr, input int hold, input bit use_exp,
                       input logic [7:0] exp_d, input bit exp_sp);
        logic [7:0] rd;
        bit rsp, ri, rdz, rinf;
        int t = 0;
        ref_eval(op, a, b, rd, rsp, ri, rdz, rinf);
        if (use_exp) begin rd = exp_d; rsp = exp_sp; end
        while (!in_ready && t < 20) begin @(negedge clk); t++; end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL %s.ready_timeout: in_ready=%0b required 1", name, in_ready);
        end
        in_valid = 1'b1; in_op = op; in0 = a; in1 = b;
        @(negedge clk);
        // EVAL: scramble inputs, they must be ignored
        in_op = 2'($urandom); in0 = 8'($urandom); in1 = 8'($urandom);
        flags_clr = clr;
        chk({name, ".eval_out_valid"}, {7'b0, out_valid}, 8'h00);
        chk({name, ".eval_in_ready"}, {7'b0, in_ready}, 8'h00);
        @(negedge clk);
        flags_clr = 1'b0;
        if (clr) begin m_inv = 0; m_dz = 0; m_inf = 0; m_cnt = 0; end
        if (rsp) begin
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_inv |= ri; m_dz |= rdz; m_inf |= rinf;
        end
        chk({name, ".out_valid"}, {7'b0, out_valid}, 8'h01);
        chk({name, ".res_data"}, res_data, rd);
        chk({name, ".res_special"}, {7'b0, res_special}, {7'b0, rsp});
        chk_status(name);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({name, ".hold_out_valid"}, {7'b0, out_valid}, 8'h01);
            chk({name, ".hold_in_ready"}, {7'b0, in_ready}, 8'h00);
            chk({name, ".hold_res_data"}, res_data, rd);
            chk_status({name, ".hold"});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, ".idle_out_valid"}, {7'b0, out_valid}, 8'h00);
    endtask

    function automatic logic [7:0] rnd_fp();
        logic s = 1'($urandom);
        case ($urandom_range(0, 4))
            0: return {s, 4'hF, 3'($urandom_range(1, 7))};
            1: return {s, 7'h78};
            2: return {s, 7'h00};
            3: return {s, 4'h0, 3'($urandom_range(1, 7))};
            default: return {s, 4'($urandom_range(1, 14)), 3'($urandom)};
        endcase
    endfunction

    task automatic chk_reset_outputs(input string name);
        chk({name, ".in_ready"}, {7'b0, in_ready}, 8'h00);
        chk({name, ".out_valid"}, {7'b0, out_valid}, 8'h00);
        chk({name, ".res_data"}, res_data, 8'h00);
        chk({name, ".res_special"}, {7'b0, res_special}, 8'h00);
        chk({name, ".flags"}, {5'b0, flag_invalid, flag_div0, flag_inf}, 8'h00);
        chk({name, ".count"}, exc_count, 8'h00);
    endtask

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [7:0] a, b;
        bit         clr;
        int         hold;
        logic [7:0] exp_d;
        bit         exp_sp;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{"add_nan_zero",   2'd0, 8'h7C, 8'h00, 1'b0, 0, 8'h7C, 1'b1};
        tbl[1]  = '{"add_pinf_ninf",  2'd0, 8'h78, 8'hF8, 1'b0, 0, 8'h7C, 1'b1};
        tbl[2]  = '{"sub_pinf_pinf",  2'd1, 8'h78, 8'h78, 1'b0, 0, 8'h7C, 1'b1};
        tbl[3]  = '{"add_ninf_fin",   2'd0, 8'hF8, 8'h38, 1'b0, 0, 8'hF8, 1'b1};
        tbl[4]  = '{"div_pos_zero",   2'd3, 8'h38, 8'h00, 1'b0, 0, 8'h78, 1'b1};
        tbl[5]  = '{"div_neg_zero",   2'd3, 8'hB8, 8'h00, 1'b0, 0, 8'hF8, 1'b1};
        tbl[6]  = '{"div_zero_zero",  2'd3, 8'h00, 8'h00, 1'b0, 0, 8'h7C, 1'b1};
        tbl[7]  = '{"div_fin_ninf",   2'd3, 8'h38, 8'hF8, 1'b0, 0, 8'h80, 1'b1};
        tbl[8]  = '{"mul_fin_fin",    2'd2, 8'h38, 8'h38, 1'b0, 0, 8'h00, 1'b0};
        tbl[9]  = '{"mul_inf_negz",   2'd2, 8'h78, 8'h80, 1'b0, 5, 8'h7C, 1'b1};
        tbl[10] = '{"sub_pinf_ninf",  2'd1, 8'h78, 8'hF8, 1'b0, 0, 8'h78, 1'b1};
        tbl[11] = '{"mul_ninf_neg",   2'd2, 8'hF8, 8'hB8, 1'b0, 0, 8'h78, 1'b1};
        tbl[12] = '{"div_pinf_neg",   2'd3, 8'h78, 8'hB8, 1'b0, 0, 8'hF8, 1'b1};
        tbl[13] = '{"add_fin_fin",    2'd0, 8'h38, 8'hB8, 1'b0, 0, 8'h00, 1'b0};
        tbl[14] = '{"div_zero_fin",   2'd3, 8'h00, 8'h38, 1'b0, 0, 8'h00, 1'b0};
        tbl[15] = '{"clr_with_nan",   2'd0, 8'h7C, 8'h78, 1'b1, 0, 8'h7C, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; in0 = 8'h00; in1 = 8'h00;
        out_ready = 1'b0; flags_clr = 1'b0;
        m_inv = 0; m_dz = 0; m_inf = 0; m_cnt = 0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset.in_ready", {7'b0, in_ready}, 8'h01);

        foreach (tbl[i])
            txn(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].clr, tbl[i].hold,
                1'b1, tbl[i].exp_d, tbl[i].exp_sp);

        // standalone clear while idle
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        m_inv = 0; m_dz = 0; m_inf = 0; m_cnt = 0;
        chk_status("idle_clear");

        // reset asserted while the result is being held
        txn("pre_reset", 2'd3, 8'h38, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b0);
        in_valid = 1'b1; in_op = 2'd0; in0 = 8'h7C; in1 = 8'h00;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("hold_before_reset.out_valid", {7'b0, out_valid}, 8'h01);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("reset_in_hold");
        m_inv = 0; m_dz = 0; m_inf = 0; m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("reset_release.in_ready", {7'b0, in_ready}, 8'h01);
        @(negedge clk);
        txn("after_reset", 2'd2, 8'hF8, 8'h38, 1'b0, 0, 1'b0, 8'h00, 1'b0);

        // randomized requests against the model
        for (int i = 0; i < 150; i++)
            txn("rand", 2'($urandom), rnd_fp(), rnd_fp(), ($urandom_range(0, 7) == 0),
                $urandom_range(0, 2), 1'b0, 8'h00, 1'b0);

        // counter saturation
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        m_inv = 0; m_dz = 0; m_inf = 0; m_cnt = 0;
        for (int i = 0; i < 260; i++)
            txn("sat", 2'($urandom), {1'($urandom), 4'hF, 3'($urandom_range(1, 7))}, rnd_fp(),
                1'b0, 0, 1'b0, 8'h00, 1'b0);
        chk("saturated_count", exc_count, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
